seq_mac: RTL

Parametrised, multi-cycle signed multiply-accumulate unit for the matrix coprocessor datapath. Replaces the single-cycle 8-bit combinational multiplier with one that has:
- a configurable operand width;
- a guarded internal accumulator, so matrix dot products are built one element per operation;
- a start/busy/done handshake;
- a saturated, flagged narrow result.

It sits between the matrix element sequencer and the result write-back.

---
 rtl/seq_mac_if.sv | 29 ++
 rtl/seq_mac.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_mac_if.sv
// Handshake and result bus between the matrix element sequencer and seq_mac.
// The sequencer drives the master side; seq_mac is the slave.
interface seq_mac_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 4
);
  localparam int unsigned ACC_W = 2 * WIDTH + GUARD;

  logic                    start;
  logic [1:0]              mode;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] prod;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_sat;

  modport master (
    output start, mode, a, b,
    input  busy, done, prod, ovf, acc, acc_sat
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, prod, ovf, acc, acc_sat
  );
endinterface

// File: rtl/seq_mac.sv
// Multi-cycle signed multiply-accumulate: radix-2 Booth multiplier, one step per
// cycle, feeding a guarded saturating accumulator and a saturated narrow result.
module seq_mac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mac_if.slave mac
);

  localparam int unsigned ACC_W = 2 * WIDTH + GUARD;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned PP_W  = 2 * WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_MAC  = 2'b01;
  localparam logic [1:0] MODE_MSUB = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] PROD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] PROD_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [WIDTH-1:0] mcand_q, mcand_d;
  logic [PP_W-1:0]         pp_q, pp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] prod_q, prod_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_sat_q, acc_sat_d;

  logic signed [WIDTH:0]     m_ext, hi, hi_sum;
  logic [PP_W-1:0]           pp_step;
  logic signed [2*WIDTH-1:0] prod_full;
  logic signed [SUM_W-1:0]   p_ext, acc_ext, sum_r;
  logic                      acc_clamp;
  logic signed [ACC_W-1:0]   acc_new;
  logic [ACC_W-WIDTH:0]      upper;
  logic                      prod_fits;
  logic signed [WIDTH-1:0]   prod_new;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MUL;
      mcand_q   <= '0;
      pp_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_q    <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mcand_q   <= mcand_d;
      pp_q      <= pp_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prod_q    <= prod_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (mac.start && (mac.mode != MODE_CLR)) state_d = ST_CALC;
      ST_CALC:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Booth step on {hi, lo, q-1}; hi carries one extra bit so -M of the most negative multiplicand fits
  always_comb begin
    m_ext = {mcand_q[WIDTH-1], mcand_q};
    hi    = pp_q[PP_W-1:WIDTH+1];
    case (pp_q[1:0])
      2'b01:   hi_sum = hi + m_ext;
      2'b10:   hi_sum = hi - m_ext;
      default: hi_sum = hi;
    endcase
    pp_step   = $signed({hi_sum, pp_q[WIDTH:0]}) >>> 1;
    prod_full = pp_q[2*WIDTH:1];

    p_ext   = SUM_W'(prod_full);
    acc_ext = SUM_W'(acc_q);
    case (mode_q)
      MODE_MAC:  sum_r = acc_ext + p_ext;
      MODE_MSUB: sum_r = acc_ext - p_ext;
      default:   sum_r = p_ext;
    endcase

    // One spare sum bit is enough to detect leaving the ACC_W signed range
    acc_clamp = sum_r[SUM_W-1] ^ sum_r[SUM_W-2];
    if (acc_clamp) acc_new = sum_r[SUM_W-1] ? ACC_MIN : ACC_MAX;
    else           acc_new = sum_r[ACC_W-1:0];

    upper     = acc_new[ACC_W-1:WIDTH-1];
    prod_fits = (&upper) | ~(|upper);
    if (prod_fits) prod_new = acc_new[WIDTH-1:0];
    else           prod_new = acc_new[ACC_W-1] ? PROD_MIN : PROD_MAX;
  end

  // Output and datapath next values
  always_comb begin
    mode_d    = mode_q;
    mcand_d   = mcand_q;
    pp_d      = pp_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    prod_d    = prod_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (mac.start) begin
          if (mac.mode == MODE_CLR) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
            prod_d    = '0;
            ovf_d     = 1'b0;
            done_d    = 1'b1;
          end else begin
            mode_d  = mac.mode;
            mcand_d = mac.a;
            pp_d    = {(WIDTH + 1)'(0), mac.b, 1'b0};
            cnt_d   = '0;
          end
        end
      end
      ST_CALC: begin
        pp_d  = pp_step;
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_FINISH: begin
        acc_d     = acc_new;
        acc_sat_d = (mode_q == MODE_MUL) ? 1'b0 : (acc_sat_q | acc_clamp);
        prod_d    = prod_new;
        ovf_d     = ~prod_fits;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mac.busy    = busy_q;
  assign mac.done    = done_q;
  assign mac.prod    = prod_q;
  assign mac.ovf     = ovf_q;
  assign mac.acc     = acc_q;
  assign mac.acc_sat = acc_sat_q;

endmodule
